wave_phase_gen: RTL and testbench
=================================

Name: wave_phase_gen

Overview:
- Upstream stage of the wave lookup block. It produces the 5-bit LUT address and 3-bit wave type for a set of time-multiplexed tone channels.
- Each channel has a programmable 12-bit period divider and a 5-bit phase counter.
- Channels are serviced round-robin, one per clock. Output is registered per slot and tagged with its channel number for the downstream mixer.
- Programmed through a byte-wide register write port.

Parameters:
- NUM_CH, 4, number of channels; power of two, 2..8.
- CH_W, 2, channel index width; equals log2(NUM_CH).
- PER_W, 12, period divider width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- reg_addr_in  in  CH_W+2  {channel, field[1:0]}
- reg_data_in  in  8  write data
- reg_we_in  in  1  write strobe, one cycle
- lut_addr_out  out  5  phase address for the serviced channel
- wave_type_out  out  3  wave type of the serviced channel
- ch_out  out  CH_W  channel index of the current output
- ch_en_out  out  1  channel enable of the current output
- valid_out  out  1  output slot valid

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high; it is sampled only on the rising edge of clk_in.
- Reset state:
  - all period, phase, counter, wave_type, enable and noise registers = 0; slot counter = 0.
  - all outputs = 0, including valid_out = 0.
- Register fields (per channel ch = reg_addr_in[CH_W+1:2]):
  - field 0: period[7:0].
  - field 1: period[11:8] = data[3:0]; wave_type = data[6:4]; enable = data[7].
  - field 2: key-on. Any write sets phase to 0 and counter to period.
  - field 3: noise mode = data[0]. Only with NOISE_EN; otherwise the write is ignored.
- Register writes take effect on the clock edge where reg_we_in = 1.
- A period change does not disturb the running counter; the new value is used at the next reload.
- Slot sequencing:
  - slot counter increments every cycle and wraps NUM_CH-1 -> 0.
  - each channel is serviced once per NUM_CH cycles.
- Service of channel c (slot == c):
  - if enable = 0: counter and phase hold.
  - else if counter == 0: counter <= period; phase <= phase + 1, wrapping 31 -> 0 (5-bit modulo).
  - else: counter <= counter - 1.
  - step rate = f_clk / (NUM_CH * (period + 1)). Period 0 steps on every visit.
- Output, latency 1 cycle: on the edge that services slot c, outputs become:
  - lut_addr_out = phase before the update;
  - wave_type_out, ch_out = c, ch_en_out = enable;
  - valid_out = 1.
- valid_out stays 1 every cycle after the first post-reset edge.
- Disabled channels still emit a slot with ch_en_out = 0 and the held phase.
- Key-on write hitting the channel being serviced in the same cycle: the write wins (phase = 0, counter = period). The output slot still shows the pre-write phase.
- Field 1 write on the serviced slot: the output shows the old wave_type/enable; the new values apply from the next visit.
- rst_in asserted mid-operation: all state returns to reset values on that edge. The outputs of that edge are the reset values.

Optional Feature:
- Macro: WAVE_PHASE_NOISE_EN.
- Defined:
  - adds a 15-bit Fibonacci LFSR with taps 15,14, seeded to 15'h0001 on reset.
  - the LFSR advances one step each time any noise-mode channel phase-steps.
  - for a noise-mode channel, lut_addr_out = {5{lfsr[0]}}, so square type 0 yields random 0/1.
  - field 3 register is implemented.
- Undefined: no LFSR; field 3 writes are ignored; lut_addr_out is always the phase.

Decomposition:
- Shared package wave_pkg: field codes FLD_PER_LO = 2'd0, FLD_PER_HI_CFG = 2'd1, FLD_KEYON = 2'd2, FLD_NOISE = 2'd3; WAVE_ADDR_W = 5; WAVE_TYPE_W = 3; LFSR seed constant.
- One natural sub-module: wave_phase_ch_regs, the per-channel register file with write decode. The slot/step datapath stays in the top level.

Test Plan:
- Reset: hold rst_in 3 cycles, release -> all outputs 0 on the release edge, then valid_out = 1 with ch_out sequencing 0, 1, 2, 3, 0.
- Period 0, ch0 enabled, key-on: ch0 lut_addr_out sequences 0, 1, 2 ... 31, 0 on successive ch0 slots (every 4 clocks). Wrap 31 -> 0 is checked.
- Period 2, ch1 enabled, type 5: ch1 phase increments every 3rd ch1 slot (every 12 clocks); wave_type_out = 5 on ch1 slots only.
- Key-on write to ch2 coincident with its service slot -> that slot shows the old phase; the next ch2 slot shows 0 and counter reloaded from period.
- Enable cleared on ch3 mid-run (phase = 7) -> ch3 slots show lut_addr 7 and ch_en_out = 0 indefinitely; re-enable resumes from 7.
- WAVE_PHASE_NOISE_EN, ch0 noise, period 0 -> lut_addr_out is 0x00 or 0x1F only. The 0/1 sequence matches the reference LFSR model from seed 1 over 100 steps.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared constants for the wave phase generator: register field codes,
// output widths and the noise LFSR seed/step function.
package wave_pkg;

    localparam int WAVE_ADDR_W = 5;
    localparam int WAVE_TYPE_W = 3;

    localparam logic [1:0] FLD_PER_LO     = 2'd0;
    localparam logic [1:0] FLD_PER_HI_CFG = 2'd1;
    localparam logic [1:0] FLD_KEYON      = 2'd2;
    localparam logic [1:0] FLD_NOISE      = 2'd3;

    localparam int         LFSR_W    = 15;
    localparam logic [14:0] LFSR_SEED = 15'h0001;

    // Fibonacci step for x^15 + x^14 + 1, shifting towards the MSB.
    function automatic logic [14:0] lfsr_next(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

endpackage

// File: rtl/wave_phase_ch_regs.sv
// Per-channel register file with write decode. Field 3 (noise mode) only
// exists when WAVE_PHASE_NOISE_EN is defined; otherwise those writes are dropped.
module wave_phase_ch_regs
    import wave_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int PER_W  = 12
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic [CH_W+1:0]                         reg_addr_in,
    input  logic [7:0]                              reg_data_in,
    input  logic                                    reg_we_in,
    output logic [NUM_CH-1:0][PER_W-1:0]            period_out,
    output logic [NUM_CH-1:0][WAVE_TYPE_W-1:0]      wave_type_out,
    output logic [NUM_CH-1:0]                       enable_out,
    output logic [NUM_CH-1:0]                       noise_out,
    output logic [NUM_CH-1:0]                       keyon_out
);

    logic [CH_W-1:0]                        w_ch;
    logic [1:0]                             w_fld;
    logic [NUM_CH-1:0][PER_W-1:0]           r_period;
    logic [NUM_CH-1:0][WAVE_TYPE_W-1:0]     r_wave_type;
    logic [NUM_CH-1:0]                      r_enable;

    assign w_ch  = reg_addr_in[CH_W+1:2];
    assign w_fld = reg_addr_in[1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_period    <= '0;
            r_wave_type <= '0;
            r_enable    <= '0;
        end else if (reg_we_in) begin
            case (w_fld)
                FLD_PER_LO: r_period[w_ch][7:0] <= reg_data_in;
                FLD_PER_HI_CFG: begin
                    r_period[w_ch][PER_W-1:8] <= reg_data_in[PER_W-9:0];
                    r_wave_type[w_ch]         <= reg_data_in[6:4];
                    r_enable[w_ch]            <= reg_data_in[7];
                end
                default: ;
            endcase
        end
    end

`ifdef WAVE_PHASE_NOISE_EN
    logic [NUM_CH-1:0] r_noise;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_noise <= '0;
        end else if (reg_we_in && (w_fld == FLD_NOISE)) begin
            r_noise[w_ch] <= reg_data_in[0];
        end
    end

    assign noise_out = r_noise;
`else
    assign noise_out = '0;
`endif

    // Key-on is a one-cycle pulse consumed directly by the phase datapath.
    always_comb begin
        keyon_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            keyon_out[c] = reg_we_in && (w_fld == FLD_KEYON) && (w_ch == CH_W'(c));
        end
    end

    assign period_out    = r_period;
    assign wave_type_out = r_wave_type;
    assign enable_out    = r_enable;

endmodule

// File: rtl/wave_phase_gen.sv
// Round-robin phase generator for time-multiplexed tone channels.
// Optional noise mode (15-bit LFSR) is compiled in with WAVE_PHASE_NOISE_EN.
module wave_phase_gen
    import wave_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int PER_W  = 12
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [CH_W+1:0]         reg_addr_in,
    input  logic [7:0]              reg_data_in,
    input  logic                    reg_we_in,
    output logic [WAVE_ADDR_W-1:0]  lut_addr_out,
    output logic [WAVE_TYPE_W-1:0]  wave_type_out,
    output logic [CH_W-1:0]         ch_out,
    output logic                    ch_en_out,
    output logic                    valid_out
);

    logic [NUM_CH-1:0][PER_W-1:0]           w_period;
    logic [NUM_CH-1:0][WAVE_TYPE_W-1:0]     w_wave_type;
    logic [NUM_CH-1:0]                      w_enable;
    logic [NUM_CH-1:0]                      w_noise;
    logic [NUM_CH-1:0]                      w_keyon;

    logic [CH_W-1:0]                        r_slot;
    logic [NUM_CH-1:0][WAVE_ADDR_W-1:0]     r_phase;
    logic [NUM_CH-1:0][PER_W-1:0]           r_cnt;

    logic [WAVE_ADDR_W-1:0]                 r_lut_addr;
    logic [WAVE_TYPE_W-1:0]                 r_wave_type;
    logic [CH_W-1:0]                        r_ch;
    logic                                   r_ch_en;
    logic                                   r_valid;

    logic                                   w_step;
    logic [WAVE_ADDR_W-1:0]                 w_lut_addr;

    wave_phase_ch_regs #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .PER_W  (PER_W)
    ) u_regs (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .reg_addr_in   (reg_addr_in),
        .reg_data_in   (reg_data_in),
        .reg_we_in     (reg_we_in),
        .period_out    (w_period),
        .wave_type_out (w_wave_type),
        .enable_out    (w_enable),
        .noise_out     (w_noise),
        .keyon_out     (w_keyon)
    );

    // A key-on hitting the serviced channel suppresses its phase step.
    assign w_step = w_enable[r_slot] && (r_cnt[r_slot] == '0) && !w_keyon[r_slot];

`ifdef WAVE_PHASE_NOISE_EN
    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_step && w_noise[r_slot]) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_lut_addr = w_noise[r_slot] ? {WAVE_ADDR_W{r_lfsr[0]}} : r_phase[r_slot];
`else
    assign w_lut_addr = r_phase[r_slot];
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_slot  <= '0;
            r_phase <= '0;
            r_cnt   <= '0;
        end else begin
            r_slot <= r_slot + CH_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_keyon[c]) begin
                    r_phase[c] <= '0;
                    r_cnt[c]   <= w_period[c];
                end else if ((r_slot == CH_W'(c)) && w_enable[c]) begin
                    if (r_cnt[c] == '0) begin
                        r_cnt[c]   <= w_period[c];
                        r_phase[c] <= r_phase[c] + WAVE_ADDR_W'(1);
                    end else begin
                        r_cnt[c] <= r_cnt[c] - PER_W'(1);
                    end
                end
            end
        end
    end

    // valid_out has no ready: it qualifies each registered slot and is
    // high on every cycle after the first post-reset edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_lut_addr  <= '0;
            r_wave_type <= '0;
            r_ch        <= '0;
            r_ch_en     <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_lut_addr  <= w_lut_addr;
            r_wave_type <= w_wave_type[r_slot];
            r_ch        <= r_slot;
            r_ch_en     <= w_enable[r_slot];
            r_valid     <= 1'b1;
        end
    end

    assign lut_addr_out  = r_lut_addr;
    assign wave_type_out = r_wave_type;
    assign ch_out        = r_ch;
    assign ch_en_out     = r_ch_en;
    assign valid_out     = r_valid;

endmodule

// File: tb/tb_wave_phase_gen.sv
// Directed bench for wave_phase_gen; the noise section is built only
// when WAVE_PHASE_NOISE_EN is defined.
module tb_wave_phase_gen;
    import wave_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic [CH_W+1:0]        reg_addr_in;
    logic [7:0]             reg_data_in;
    logic                   reg_we_in;
    logic [4:0]             lut_addr_out;
    logic [2:0]             wave_type_out;
    logic [CH_W-1:0]        ch_out;
    logic                   ch_en_out;
    logic                   valid_out;

    int tests = 0;
    int fails = 0;
    int nslot = 0;

    wave_phase_gen #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PER_W(12)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .reg_addr_in   (reg_addr_in),
        .reg_data_in   (reg_data_in),
        .reg_we_in     (reg_we_in),
        .lut_addr_out  (lut_addr_out),
        .wave_type_out (wave_type_out),
        .ch_out        (ch_out),
        .ch_en_out     (ch_en_out),
        .valid_out     (valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; nslot tracks which slot the next edge services.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rst_in) nslot = 0;
        else        nslot = (nslot + 1) % NUM_CH;
    endtask

    task automatic wr(input int ch, input logic [1:0] fld, input logic [7:0] d);
        reg_addr_in = {2'(ch), fld};
        reg_data_in = d;
        reg_we_in   = 1'b1;
        tick();
        reg_we_in   = 1'b0;
    endtask

    task automatic visit(input int ch);
        while (nslot != ch) tick();
        tick();
    endtask

    task automatic chk_slot(input string tag, input int ch, input int lut, input logic en, input int wt);
        chk({tag, "_ch"},    32'(ch_out),        32'(ch));
        chk({tag, "_lut"},   32'(lut_addr_out),  32'(lut));
        chk({tag, "_en"},    32'(ch_en_out),     32'(en));
        chk({tag, "_wt"},    32'(wave_type_out), 32'(wt));
        chk({tag, "_valid"}, 32'(valid_out),     32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lut"},   32'(lut_addr_out),  32'd0);
        chk({tag, "_wt"},    32'(wave_type_out), 32'd0);
        chk({tag, "_ch"},    32'(ch_out),        32'd0);
        chk({tag, "_en"},    32'(ch_en_out),     32'd0);
        chk({tag, "_valid"}, 32'(valid_out),     32'd0);
    endtask

    initial begin
        logic [14:0] m;
        logic [4:0]  exp_noise;

        rst_in      = 1'b1;
        reg_addr_in = '0;
        reg_data_in = '0;
        reg_we_in   = 1'b0;

        // Reset held three cycles, then slot sequencing 0,1,2,3,0.
        repeat (3) tick();
        chk_zero("reset");
        rst_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_slot("seq", i % NUM_CH, 0, 1'b0, 0);
        end

`ifndef WAVE_PHASE_NOISE_EN
        // Field 3 has no effect in this build; ch0 must still emit its phase.
        wr(0, FLD_NOISE, 8'h01);
`endif

        // ch0, period 0: phase steps every visit, wraps 31 -> 0.
        wr(0, FLD_PER_LO, 8'h00);
        wr(0, FLD_PER_HI_CFG, 8'h80);
        wr(0, FLD_KEYON, 8'h00);
        for (int i = 0; i < 33; i++) begin
            visit(0);
            chk_slot("p0_ch0", 0, i % 32, 1'b1, 0);
        end

        // ch1, period 2, type 5: phase steps every third visit.
        wr(1, FLD_PER_LO, 8'h02);
        wr(1, FLD_PER_HI_CFG, 8'hD0);
        wr(1, FLD_KEYON, 8'h00);
        for (int i = 0; i < 9; i++) begin
            visit(1);
            chk_slot("p2_ch1", 1, i / 3, 1'b1, 5);
        end
        visit(2);
        chk("type_ch2", 32'(wave_type_out), 32'd0);
        visit(0);
        chk("type_ch0", 32'(wave_type_out), 32'd0);

        // ch2, period 1: key-on coincident with its own service slot.
        wr(2, FLD_PER_LO, 8'h01);
        wr(2, FLD_PER_HI_CFG, 8'h80);
        wr(2, FLD_KEYON, 8'h00);
        visit(2); chk_slot("ko_pre0", 2, 0, 1'b1, 0);
        visit(2); chk_slot("ko_pre1", 2, 0, 1'b1, 0);
        visit(2); chk_slot("ko_pre2", 2, 1, 1'b1, 0);
        visit(2); chk_slot("ko_pre3", 2, 1, 1'b1, 0);
        while (nslot != 2) tick();
        wr(2, FLD_KEYON, 8'h00);
        chk_slot("ko_hit", 2, 2, 1'b1, 0);
        visit(2); chk_slot("ko_post0", 2, 0, 1'b1, 0);
        visit(2); chk_slot("ko_post1", 2, 0, 1'b1, 0);
        visit(2); chk_slot("ko_post2", 2, 1, 1'b1, 0);

        // ch3: run to phase 7, disable (phase holds), re-enable resumes.
        wr(3, FLD_PER_LO, 8'h00);
        wr(3, FLD_PER_HI_CFG, 8'h80);
        wr(3, FLD_KEYON, 8'h00);
        for (int i = 0; i < 7; i++) begin
            visit(3);
            chk_slot("run_ch3", 3, i, 1'b1, 0);
        end
        wr(3, FLD_PER_HI_CFG, 8'h00);
        for (int i = 0; i < 3; i++) begin
            visit(3);
            chk_slot("dis_ch3", 3, 7, 1'b0, 0);
        end
        wr(3, FLD_PER_HI_CFG, 8'h80);
        visit(3); chk_slot("reen0_ch3", 3, 7, 1'b1, 0);
        visit(3); chk_slot("reen1_ch3", 3, 8, 1'b1, 0);

        // Reset mid-run: that edge produces reset outputs, state cleared.
        rst_in = 1'b1;
        tick();
        chk_zero("midrst");
        rst_in = 1'b0;
        tick();
        chk_slot("midrst_ch0", 0, 0, 1'b0, 0);
        visit(3);
        chk_slot("midrst_ch3", 3, 0, 1'b0, 0);

`ifdef WAVE_PHASE_NOISE_EN
        // Noise on ch0 at period 0: output follows LFSR bit 0 from seed 1.
        wr(0, FLD_NOISE, 8'h01);
        wr(0, FLD_PER_LO, 8'h00);
        wr(0, FLD_KEYON, 8'h00);
        wr(0, FLD_PER_HI_CFG, 8'h80);
        m = 15'h0001;
        for (int i = 0; i < 100; i++) begin
            visit(0);
            exp_noise = {5{m[0]}};
            chk("noise_lut", 32'(lut_addr_out), 32'(exp_noise));
            chk("noise_range", 32'((lut_addr_out == 5'h00) || (lut_addr_out == 5'h1F)), 32'd1);
            m = {m[13:0], m[14] ^ m[13]};
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
